// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data, data first.
// Optional macro ARB_STATS_EN adds per-requester wait-cycle counters.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              imem_r,
    output logic [15:0]       instr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_bmask,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              dmem_r,
    output logic [15:0]       d_rdata,
    output logic              mem_en,
    output logic [1:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
`ifdef ARB_STATS_EN
    output logic [15:0]       if_wait_cnt,
    output logic [15:0]       d_wait_cnt,
`endif
    input  logic [15:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
    state_t state;
    logic [3:0] cnt;
    logic store;
    logic done, grant_d, grant_i, release_port;
    always_comb begin
        done         = state != IDLE && cnt == 4'd0;
        grant_d      = d_req && (state == IDLE || (state == IBUSY && (done || if_cancel)));
        // The requester retiring at this edge is never regranted; only the other side may follow.
        grant_i      = if_req && !if_cancel && ((state == IDLE && !d_req) || (state == DBUSY && done));
        release_port = (state == IBUSY && (done || if_cancel)) || (state == DBUSY && done);
        imem_r       = state == IBUSY && done && !if_cancel;
        dmem_r       = state == DBUSY && done;
        instr        = imem_r ? mem_rdata : 16'h0;
        d_rdata      = dmem_r && !store ? mem_rdata : 16'h0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            store     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= 16'h0;
        end else if (grant_d) begin
            state     <= DBUSY;
            cnt       <= CNT_INIT;
            store     <= d_we;
            mem_en    <= 1'b1;
            mem_we    <= d_we ? d_bmask : 2'b00;
            mem_addr  <= d_addr;
            mem_wdata <= d_we ? d_wdata : 16'h0;
        end else if (grant_i) begin
            state     <= IBUSY;
            cnt       <= CNT_INIT;
            store     <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 2'b00;
            mem_addr  <= if_addr;
            mem_wdata <= 16'h0;
        end else if (release_port) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            store     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= 16'h0;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end
`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_wait_cnt <= 16'h0;
            d_wait_cnt  <= 16'h0;
        end else begin
            if (if_req && !if_cancel && !imem_r && if_wait_cnt != 16'hFFFF)
                if_wait_cnt <= if_wait_cnt + 16'd1;
            if (d_req && !dmem_r && d_wait_cnt != 16'hFFFF)
                d_wait_cnt <= d_wait_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a timeline model
// of grant order and fixed access latency.
module tb_mem_port_arbiter;
    localparam int L = 4;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        if_req = 1'b0, if_cancel = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [1:0]  d_bmask = 2'b00;
    logic [15:0] if_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0, junk = 16'h0;
    logic [15:0] mem_rdata, instr, d_rdata, mem_addr, mem_wdata;
    logic        imem_r, dmem_r, mem_en;
    logic [1:0]  mem_we;
    int checks = 0, errors = 0;
`ifdef ARB_STATS_EN
    logic [15:0] if_wait_cnt, d_wait_cnt;
`endif

    mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .imem_r(imem_r), .instr(instr),
        .d_req(d_req), .d_we(d_we), .d_bmask(d_bmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .dmem_r(dmem_r), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_STATS_EN
        .if_wait_cnt(if_wait_cnt), .d_wait_cnt(d_wait_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_of(logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Memory returns address-derived data while the port is in use, noise otherwise.
    always_comb mem_rdata = mem_en ? rd_of(mem_addr) : junk;

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, ".imem_r"}, 16'(imem_r), 16'h0);
        check({tag, ".dmem_r"}, 16'(dmem_r), 16'h0);
        check({tag, ".mem_en"}, 16'(mem_en), 16'h0);
        check({tag, ".mem_we"}, 16'(mem_we), 16'h0);
        check({tag, ".mem_addr"}, mem_addr, 16'h0);
        check({tag, ".mem_wdata"}, mem_wdata, 16'h0);
        check({tag, ".instr"}, instr, 16'h0);
        check({tag, ".d_rdata"}, d_rdata, 16'h0);
    endtask

    // Requests raised together in cycle 0 from IDLE. Data owns cycles 1..L, fetch the next L
    // cycles (or 1..L alone). coff >= 0 pulses if_cancel at that offset into the fetch window.
    task automatic run(bit di, bit dd, bit dwe, logic [1:0] bm, logic [15:0] ia,
                       logic [15:0] da, logic [15:0] wd, int coff);
        int s, fe, c, iend, last;
        bit dwin, iwin, edr, eir;
        s    = dd ? L + 1 : 1;
        fe   = s + L - 1;
        c    = (di && coff >= 0) ? s + coff : -1;
        iend = c >= 0 ? c : fe;
        last = di ? iend : L;
        for (int k = 0; k <= last + 1; k++) begin
            @(posedge clk); #1;
            junk      = 16'($urandom);
            if_addr   = ia;
            d_addr    = da;
            d_we      = dwe;
            d_bmask   = bm;
            d_wdata   = wd;
            if_req    = di && k <= iend;
            d_req     = dd && k <= L;
            if_cancel = k == c;
            @(negedge clk);
            dwin = dd && k >= 1 && k <= L;
            iwin = di && k >= s && k <= iend;
            edr  = dd && k == L;
            eir  = di && c < 0 && k == fe;
            check("mem_en", 16'(mem_en), 16'(dwin || iwin));
            check("dmem_r", 16'(dmem_r), 16'(edr));
            check("imem_r", 16'(imem_r), 16'(eir));
            check("instr", instr, eir ? rd_of(ia) : 16'h0);
            check("d_rdata", d_rdata, (edr && !dwe) ? rd_of(da) : 16'h0);
            if (dwin) begin
                check("d.mem_addr", mem_addr, da);
                check("d.mem_we", 16'(mem_we), dwe ? 16'(bm) : 16'h0);
                if (dwe) check("d.mem_wdata", mem_wdata, wd);
            end
            if (iwin) begin
                check("i.mem_addr", mem_addr, ia);
                check("i.mem_we", 16'(mem_we), 16'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset_n = 1'b1;
        run(1, 0, 0, 2'b00, 16'h3000, 16'h0, 16'h0, -1);
        run(1, 1, 0, 2'b00, 16'h3010, 16'h4000, 16'h0, -1);
        run(0, 1, 1, 2'b10, 16'h0, 16'h4002, 16'hAB00, -1);
        run(1, 0, 0, 2'b00, 16'h3020, 16'h0, 16'h0, 1);
        run(1, 0, 0, 2'b00, 16'h3050, 16'h0, 16'h0, -1);
        run(1, 0, 0, 2'b00, 16'h3060, 16'h0, 16'h0, L - 1);
        run(1, 1, 1, 2'b01, 16'h3070, 16'h4100, 16'h00CD, 0);
        // Reset in the second cycle of a load abandons it without a ready.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4200; if_req = 1'b0; if_cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        d_req = 1'b0;
        #1 check_all_zero("midreset");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset.dmem_r", 16'(dmem_r), 16'h0);
            check("post_reset.mem_en", 16'(mem_en), 16'h0);
        end
        run(0, 1, 0, 2'b00, 16'h0, 16'h4204, 16'h0, -1);
        for (int n = 0; n < 40; n++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(1, 3));
            run(sel[0], sel[1], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L - 1)) : -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
